bp_me_stream_mem_responder: RTL and testbench



---
 rtl/bp_me_pkg.sv | 66 ++++++
 rtl/bp_me_stream_beat_gen.sv | 76 +++++++
 rtl/bp_me_stream_mem_responder.sv | 113 +++++++++++
 tb/tb_bp_me_stream_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared BedRock stream memory types: default processor config, mem header, endpoint FSM states.
// Also provides the beat-count helper used by every stream endpoint.
package bp_me_pkg;

    localparam int paddr_width_p        = 40;
    localparam int did_width_p          = 4;
    localparam int lce_id_width_p       = 4;
    localparam int lce_assoc_p          = 8;
    localparam int bedrock_fill_width_p = 64;
    localparam int block_width_p        = 512;

    localparam int fill_bytes_lp     = bedrock_fill_width_p / 8;
    localparam int lg_fill_bytes_lp  = $clog2(fill_bytes_lp);
    localparam int max_beats_lp      = block_width_p / bedrock_fill_width_p;
    localparam int lg_max_beats_lp   = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [did_width_p-1:0]         did;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s  payload;
        bp_bedrock_msg_size_e     size;
        logic [paddr_width_p-1:0] addr;
        bp_bedrock_mem_type_e     msg_type;
    } bp_bedrock_mem_header_s;

    typedef enum logic [2:0] {
        e_reset,
        e_ready,
        e_write,
        e_wr_resp,
        e_read
    } bp_me_stream_mem_state_e;

    // Sub-fill-width messages still occupy one beat.
    function automatic int unsigned bedrock_stream_beats(input logic [2:0] size,
                                                         input int unsigned fill_bytes);
        int unsigned bytes;
        bytes = 32'd1 << size;
        return (bytes <= fill_bytes) ? 32'd1 : bytes / fill_bytes;
    endfunction

endpackage

// File: rtl/bp_me_stream_beat_gen.sv
// Beat index generator: latches aligned base, beat mask and start word; yields index and last flag.
// BP_ME_STREAM_MEM_RESPONDER_WRAP_EN selects critical-word-first wrap within the aligned block.
module bp_me_stream_beat_gen
    import bp_me_pkg::*;
#(
    parameter int els_p = 1024,
    localparam int lg_els_lp = $clog2(els_p)
)(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_load,
    input  logic                       i_adv,
    input  logic [lg_els_lp-1:0]       i_word,
    input  bp_bedrock_msg_size_e       i_size,
    output logic [lg_els_lp-1:0]       o_idx0,
    output logic                       o_last0,
    output logic [lg_els_lp-1:0]       o_idx,
    output logic                       o_last
);
    int unsigned                 w_beats;
    logic [lg_max_beats_lp-1:0]  w_mask_in;
    logic [lg_els_lp-1:0]        w_mask_wide;
    logic [lg_els_lp-1:0]        w_base_in;
    logic [lg_max_beats_lp-1:0]  r_cnt;
    logic [lg_max_beats_lp-1:0]  r_mask;
    logic [lg_els_lp-1:0]        r_base;

    // Requests larger than a block are clamped to one block of beats.
    always_comb begin
        w_beats = bedrock_stream_beats(i_size, fill_bytes_lp);
        if (w_beats > max_beats_lp) begin
            w_beats = max_beats_lp;
        end
        w_mask_in = lg_max_beats_lp'(w_beats - 32'd1);
    end

    assign w_mask_wide = lg_els_lp'(w_mask_in);
    assign w_base_in   = i_word & ~w_mask_wide;
    assign o_last0     = (w_mask_in == '0);
    assign o_last      = (r_cnt == r_mask);

`ifdef BP_ME_STREAM_MEM_RESPONDER_WRAP_EN
    logic [lg_max_beats_lp-1:0] r_start;
    logic [lg_max_beats_lp-1:0] w_start_in;

    assign w_start_in = lg_max_beats_lp'(i_word & w_mask_wide);
    assign o_idx0     = i_word;
    assign o_idx      = r_base | lg_els_lp'((r_start + r_cnt) & r_mask);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start <= '0;
        end else if (i_load) begin
            r_start <= w_start_in;
        end
    end
`else
    assign o_idx0 = w_base_in;
    assign o_idx  = r_base | lg_els_lp'(r_cnt);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_mask <= '0;
            r_base <= '0;
        end else if (i_load) begin
            r_base <= w_base_in;
            r_mask <= w_mask_in;
            r_cnt  <= i_adv ? (lg_max_beats_lp'(1) & w_mask_in) : '0;
        end else if (i_adv) begin
            r_cnt <= (r_cnt + lg_max_beats_lp'(1)) & r_mask;
        end
    end

endmodule

// File: rtl/bp_me_stream_mem_responder.sv
// BedRock stream memory endpoint over a flop-array store; responds 1 cycle after accept, 1 beat/cycle.
// Response beats hold while mem_rev_ready_and_i is low; optional BP_ME_STREAM_MEM_RESPONDER_WRAP_EN.
module bp_me_stream_mem_responder
    import bp_me_pkg::*;
#(
    parameter int els_p = 1024
)(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  bp_bedrock_mem_header_s          mem_fwd_header_i,
    input  logic [bedrock_fill_width_p-1:0] mem_fwd_data_i,
    input  logic                            mem_fwd_v_i,
    output logic                            mem_fwd_ready_and_o,
    output bp_bedrock_mem_header_s          mem_rev_header_o,
    output logic [bedrock_fill_width_p-1:0] mem_rev_data_o,
    output logic                            mem_rev_v_o,
    input  logic                            mem_rev_ready_and_i
);
    localparam int lg_els_lp = $clog2(els_p);

    bp_me_stream_mem_state_e          r_state;
    bp_bedrock_mem_header_s           r_hdr;
    logic [bedrock_fill_width_p-1:0]  r_mem [els_p];

    logic                     w_fwd_hs, w_rev_hs, w_is_rd, w_is_wr;
    logic                     w_load, w_adv, w_we, w_last0, w_last;
    logic [lg_els_lp-1:0]     w_idx0, w_idx, w_widx;
    logic [fill_bytes_lp-1:0] w_be;
    int unsigned              w_bytes, w_off;

    assign mem_fwd_ready_and_o = !reset_i && (r_state == e_ready || r_state == e_write);
    assign mem_rev_v_o         = !reset_i && (r_state == e_wr_resp || r_state == e_read);
    assign mem_rev_header_o    = r_hdr;
    assign mem_rev_data_o      = (r_state == e_read) ? r_mem[w_idx] : '0;

    assign w_fwd_hs = mem_fwd_v_i && mem_fwd_ready_and_o;
    assign w_rev_hs = mem_rev_v_o && mem_rev_ready_and_i;
    assign w_is_rd  = (mem_fwd_header_i.msg_type == e_bedrock_mem_rd)
                   || (mem_fwd_header_i.msg_type == e_bedrock_mem_uc_rd);
    assign w_is_wr  = (mem_fwd_header_i.msg_type == e_bedrock_mem_wr)
                   || (mem_fwd_header_i.msg_type == e_bedrock_mem_uc_wr);

    assign w_load = (r_state == e_ready) && w_fwd_hs;
    assign w_we   = (w_load && w_is_wr) || ((r_state == e_write) && w_fwd_hs);
    assign w_adv  = w_we || ((r_state == e_read) && w_rev_hs);
    assign w_widx = (r_state == e_ready) ? w_idx0 : w_idx;

    bp_me_stream_beat_gen #(.els_p(els_p)) u_beat_gen (
        .i_clk   (clk_i),
        .i_reset (reset_i),
        .i_load  (w_load),
        .i_adv   (w_adv),
        .i_word  (mem_fwd_header_i.addr[lg_fill_bytes_lp +: lg_els_lp]),
        .i_size  (mem_fwd_header_i.size),
        .o_idx0  (w_idx0),
        .o_last0 (w_last0),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    // Only a sub-fill beat 0 is partial; later beats of a block are always full width.
    always_comb begin
        w_bytes = 32'd1 << mem_fwd_header_i.size;
        w_off   = 32'(mem_fwd_header_i.addr[lg_fill_bytes_lp-1:0]) & ~(w_bytes - 32'd1);
        w_be    = '0;
        for (int unsigned b = 0; b < fill_bytes_lp; b++) begin
            w_be[b] = (r_state != e_ready) || (w_bytes >= fill_bytes_lp)
                   || ((b >= w_off) && (b < w_off + w_bytes));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < fill_bytes_lp; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= mem_fwd_data_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_reset;
            r_hdr   <= '0;
        end else begin
            case (r_state)
                e_reset: r_state <= e_ready;
                e_ready: begin
                    if (w_fwd_hs) begin
                        r_hdr <= mem_fwd_header_i;
                        if (w_is_rd) begin
                            r_state <= e_read;
                        end else if (w_is_wr && !w_last0) begin
                            r_state <= e_write;
                        end else begin
                            r_state <= e_wr_resp;
                        end
                    end
                end
                e_write:   if (w_fwd_hs && w_last) r_state <= e_wr_resp;
                e_wr_resp: if (w_rev_hs) r_state <= e_ready;
                e_read:    if (w_rev_hs && w_last) r_state <= e_ready;
                default:   r_state <= e_reset;
            endcase
        end
    end

    // A beat offered right after the last write beat means the initiator overran its header's count.
    a_no_extra_beat: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_wr_resp && $past(r_state) == e_write) |-> !mem_fwd_v_i);

endmodule

// File: tb/tb_bp_me_stream_mem_responder.sv
// Scoreboard bench for the stream memory responder: write/read, block, back-pressure, byte write, reset, wrap.
module tb_bp_me_stream_mem_responder;
    import bp_me_pkg::*;

    typedef struct {
        bp_bedrock_mem_header_s hdr;
        logic [63:0]            data;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   reset_i = 1'b1;
    bp_bedrock_mem_header_s mem_fwd_header_i = '0;
    logic [63:0]            mem_fwd_data_i = '0;
    logic                   mem_fwd_v_i = 1'b0;
    logic                   mem_fwd_ready_and_o;
    bp_bedrock_mem_header_s mem_rev_header_o;
    logic [63:0]            mem_rev_data_o;
    logic                   mem_rev_v_o;
    logic                   mem_rev_ready_and_i = 1'b0;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bp_me_stream_mem_responder #(.els_p(1024)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .mem_fwd_header_i    (mem_fwd_header_i),
        .mem_fwd_data_i      (mem_fwd_data_i),
        .mem_fwd_v_i         (mem_fwd_v_i),
        .mem_fwd_ready_and_o (mem_fwd_ready_and_o),
        .mem_rev_header_o    (mem_rev_header_o),
        .mem_rev_data_o      (mem_rev_data_o),
        .mem_rev_v_o         (mem_rev_v_o),
        .mem_rev_ready_and_i (mem_rev_ready_and_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                      input logic [paddr_width_p-1:0] a,
                                                      input bp_bedrock_msg_size_e s);
        bp_bedrock_mem_header_s h;
        h = '0;
        h.msg_type       = t;
        h.addr           = a;
        h.size           = s;
        h.payload.lce_id = 4'h3;
        h.payload.did    = 4'h1;
        h.payload.way_id = 3'h2;
        return h;
    endfunction

    task automatic push_exp(input bp_bedrock_mem_header_s h, input logic [63:0] d);
        exp_t e;
        e.hdr  = h;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic fwd_beat(input bp_bedrock_mem_header_s h, input logic [63:0] d);
        int n = 0;
        mem_fwd_header_i = h;
        mem_fwd_data_i   = d;
        mem_fwd_v_i      = 1'b1;
        while (mem_fwd_ready_and_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (mem_fwd_ready_and_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL fwd_timeout: ready_and=%b after %0d cycles, expected 1", mem_fwd_ready_and_o, n);
            mem_fwd_v_i = 1'b0;
            return;
        end
        @(negedge clk_i);
        mem_fwd_v_i = 1'b0;
    endtask

    task automatic collect(input int n, input int stall_at, input int stall_len, input bit chk_gap);
        int   got = 0;
        int   cyc = 0;
        int   last = 0;
        int   stalled = 0;
        exp_t e;
        while (got < n && cyc < 200) begin
            if (mem_rev_v_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rev_unexpected: got data %h, expected no beat", mem_rev_data_o);
                    mem_rev_ready_and_i = 1'b1;
                    got = n;
                end else if (got == stall_at && stalled < stall_len) begin
                    mem_rev_ready_and_i = 1'b0;
                    stalled++;
                    checks++;
                    if (mem_rev_data_o !== exp_q[0].data || mem_rev_header_o !== exp_q[0].hdr) begin
                        errors++;
                        $display("FAIL stall_hold beat %0d: got %h/%h, expected %h/%h", got,
                                 mem_rev_data_o, mem_rev_header_o, exp_q[0].data, exp_q[0].hdr);
                    end
                end else begin
                    e = exp_q.pop_front();
                    mem_rev_ready_and_i = 1'b1;
                    checks++;
                    if (mem_rev_data_o !== e.data) begin
                        errors++;
                        $display("FAIL beat_data %0d: got %h, expected %h", got, mem_rev_data_o, e.data);
                    end
                    checks++;
                    if (mem_rev_header_o !== e.hdr) begin
                        errors++;
                        $display("FAIL beat_hdr %0d: got %h, expected %h", got, mem_rev_header_o, e.hdr);
                    end
                    if (chk_gap && got > 0) begin
                        checks++;
                        if (cyc != last + 1) begin
                            errors++;
                            $display("FAIL beat_gap %0d: got cycle %0d, expected %0d", got, cyc, last + 1);
                        end
                    end
                    last = cyc;
                    got++;
                end
            end else begin
                mem_rev_ready_and_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        mem_rev_ready_and_i = 1'b0;
        if (got < n) begin
            checks++; errors++;
            $display("FAIL rev_timeout: got %0d beats, expected %0d", got, n);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (mem_fwd_ready_and_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b, expected 0", mem_fwd_ready_and_o);
        end
        checks++;
        if (mem_rev_v_o !== 1'b0) begin
            errors++; $display("FAIL reset_v: got %b, expected 0", mem_rev_v_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_fwd_ready_and_o !== 1'b1) begin
            errors++; $display("FAIL reset_exit_ready: got %b, expected 1", mem_fwd_ready_and_o);
        end
    endtask

    task automatic test_single();
        bp_bedrock_mem_header_s h;
        h = mk_hdr(e_bedrock_mem_uc_wr, 40'h80, e_bedrock_msg_size_8);
        push_exp(h, 64'h0);
        fwd_beat(h, 64'hDEADBEEF_CAFEF00D);
        checks++;
        if (mem_rev_v_o !== 1'b1) begin
            errors++; $display("FAIL wr_latency: v=%b, expected 1", mem_rev_v_o);
        end
        collect(1, -1, 0, 1'b0);
        h = mk_hdr(e_bedrock_mem_uc_rd, 40'h80, e_bedrock_msg_size_8);
        push_exp(h, 64'hDEADBEEF_CAFEF00D);
        fwd_beat(h, 64'h0);
        checks++;
        if (mem_rev_v_o !== 1'b1) begin
            errors++; $display("FAIL rd_latency: v=%b, expected 1", mem_rev_v_o);
        end
        collect(1, -1, 0, 1'b0);
    endtask

    task automatic test_block();
        bp_bedrock_mem_header_s h;
        h = mk_hdr(e_bedrock_mem_wr, 40'h1000, e_bedrock_msg_size_64);
        push_exp(h, 64'h0);
        for (int k = 0; k < 8; k++) fwd_beat(h, 64'(k + 1));
        collect(1, -1, 0, 1'b0);
        h = mk_hdr(e_bedrock_mem_rd, 40'h1000, e_bedrock_msg_size_64);
        for (int k = 0; k < 8; k++) push_exp(h, 64'(k + 1));
        fwd_beat(h, 64'h0);
        collect(8, -1, 0, 1'b1);
        checks++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
            errors++;
            $display("FAIL block_end: v=%b ready=%b, expected v=0 ready=1", mem_rev_v_o, mem_fwd_ready_and_o);
        end
    endtask

    task automatic test_backpressure();
        bp_bedrock_mem_header_s h;
        h = mk_hdr(e_bedrock_mem_rd, 40'h1000, e_bedrock_msg_size_64);
        for (int k = 0; k < 8; k++) push_exp(h, 64'(k + 1));
        fwd_beat(h, 64'h0);
        collect(8, 2, 3, 1'b0);
        checks++;
        if (exp_q.size() != 0 || mem_rev_v_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_leftover: queue=%0d v=%b, expected 0 and 0", exp_q.size(), mem_rev_v_o);
        end
    endtask

    task automatic test_byte_write();
        bp_bedrock_mem_header_s h;
        h = mk_hdr(e_bedrock_mem_uc_wr, 40'h80, e_bedrock_msg_size_8);
        push_exp(h, 64'h0);
        fwd_beat(h, 64'h0);
        collect(1, -1, 0, 1'b0);
        h = mk_hdr(e_bedrock_mem_uc_wr, 40'h83, e_bedrock_msg_size_1);
        push_exp(h, 64'h0);
        fwd_beat(h, 64'hAAAAAAAA_AAAAAAAA);
        collect(1, -1, 0, 1'b0);
        h = mk_hdr(e_bedrock_mem_uc_rd, 40'h80, e_bedrock_msg_size_8);
        push_exp(h, 64'h00000000_AA000000);
        fwd_beat(h, 64'h0);
        collect(1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_midop();
        bp_bedrock_mem_header_s h;
        h = mk_hdr(e_bedrock_mem_rd, 40'h1000, e_bedrock_msg_size_64);
        for (int k = 0; k < 8; k++) push_exp(h, 64'(k + 1));
        fwd_beat(h, 64'h0);
        collect(4, -1, 0, 1'b1);
        reset_i = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        checks++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: v=%b ready=%b, expected 0 0", mem_rev_v_o, mem_fwd_ready_and_o);
        end
        @(negedge clk_i);
        checks++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_hold: v=%b ready=%b, expected 0 0", mem_rev_v_o, mem_fwd_ready_and_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
            errors++;
            $display("FAIL midop_recover: v=%b ready=%b, expected 0 1", mem_rev_v_o, mem_fwd_ready_and_o);
        end
        h = mk_hdr(e_bedrock_mem_uc_rd, 40'h83, e_bedrock_msg_size_1);
        push_exp(h, 64'h00000000_AA000000);
        fwd_beat(h, 64'h0);
        collect(1, -1, 0, 1'b0);
    endtask

    task automatic test_wrap();
        bp_bedrock_mem_header_s h;
        int start;
`ifdef BP_ME_STREAM_MEM_RESPONDER_WRAP_EN
        start = 5;
`else
        start = 0;
`endif
        h = mk_hdr(e_bedrock_mem_rd, 40'h1028, e_bedrock_msg_size_64);
        for (int k = 0; k < 8; k++) push_exp(h, 64'(((start + k) % 8) + 1));
        fwd_beat(h, 64'h0);
        collect(8, -1, 0, 1'b1);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single();
        test_block();
        test_backpressure();
        test_byte_write();
        test_reset_midop();
        test_wrap();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
